// File: rtl/mips_control_pkg.sv
// -----------------------------------------------------------------------------
// mips_control_pkg
// Shared definitions for the multicycle MIPS control path: opcode constants,
// FSM state encodings, alu_op codes (also consumed by the ALU control decoder),
// and the alu_src_b / pc_source mux select codes.
// Optional feature macro: UCMC_JUMP_EN (adds the JUMP state for opcode 000010).
// -----------------------------------------------------------------------------
package mips_control_pkg;

  // Opcodes, instruction bits [31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  // FSM states; the numeric values are visible on the debug state port
  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_REX    = 4'd6,
    ST_RWB    = 4'd7,
    ST_BEQ    = 4'd8,
    ST_IEX    = 4'd9,
    ST_IWB    = 4'd10,
`ifdef UCMC_JUMP_EN
    ST_JUMP   = 4'd11,
`endif
    ST_TRAP   = 4'd12
  } state_t;

  // alu_op codes shared with the ALU control decoder
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_SLT   = 3'b100;
  localparam logic [2:0] ALU_AND   = 3'b101;

  // alu_src_b selects
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // pc_source selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // ALU operation for the immediate-arithmetic group
  function automatic logic [2:0] itype_alu_op(input logic [5:0] op);
    logic [2:0] res;
    case (op)
      OP_ANDI: res = ALU_AND;
      OP_ORI:  res = ALU_OR;
      OP_SLTI: res = ALU_SLT;
      default: res = ALU_ADD;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/unidad_de_control_multiciclo_salidas.sv
// -----------------------------------------------------------------------------
// salidas_control_multiciclo
// Combinational state-to-output decoder for the multicycle control FSM.
// Inputs : state (current FSM state), opcode (IR[31:26]), mem_ready, zero,
//          reset (forces every strobe low while high).
// Outputs: all datapath enables and mux selects, alu_op, illegal.
// Optional feature macro: UCMC_JUMP_EN (decodes the JUMP state).
// -----------------------------------------------------------------------------
module salidas_control_multiciclo
  import mips_control_pkg::*;
(
  input  logic [3:0] state,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  input  logic       zero,
  input  logic       reset,
  output logic       pc_en,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [2:0] alu_op,
  output logic       illegal
);

  logic pc_write;
  logic branch;
  logic mem_read_c;
  logic mem_write_c;
  logic ir_write_c;
  logic reg_write_c;

  // Moore decode of state; only FETCH looks at mem_ready and only BEQ at zero
  always_comb begin
    pc_write    = 1'b0;
    branch      = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    i_or_d      = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_REG;
    pc_source   = PCSRC_ALU;
    alu_op      = ALU_ADD;
    illegal     = 1'b0;
    case (state)
      ST_FETCH: begin
        mem_read_c = 1'b1;
        alu_src_b  = SRCB_FOUR;
        // PC+4 and IR capture happen only on the cycle memory delivers
        ir_write_c = mem_ready;
        pc_write   = mem_ready;
      end
      ST_DECODE: alu_src_b = SRCB_IMM_SH2;
      ST_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      ST_MEMRD: begin
        mem_read_c = 1'b1;
        i_or_d     = 1'b1;
      end
      ST_MEMWB: begin
        reg_write_c = 1'b1;
        mem_to_reg  = 1'b1;
      end
      ST_MEMWR: begin
        mem_write_c = 1'b1;
        i_or_d      = 1'b1;
      end
      ST_REX: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      ST_RWB: begin
        reg_write_c = 1'b1;
        reg_dst     = 1'b1;
      end
      ST_BEQ: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        branch    = 1'b1;
        pc_source = PCSRC_ALUOUT;
      end
      ST_IEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = itype_alu_op(opcode);
      end
      ST_IWB: reg_write_c = 1'b1;
`ifdef UCMC_JUMP_EN
      ST_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
`endif
      ST_TRAP: illegal = 1'b1;
      default: illegal = 1'b0;
    endcase

    if (reset) begin
      pc_en     = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
    end else begin
      pc_en     = pc_write | (branch & zero);
      mem_read  = mem_read_c;
      mem_write = mem_write_c;
      ir_write  = ir_write_c;
      reg_write = reg_write_c;
    end
  end

endmodule

// File: rtl/unidad_de_control_multiciclo.sv
// -----------------------------------------------------------------------------
// unidad_de_control_multiciclo
// Multicycle main control FSM for the MIPS datapath. Holds the state register
// and next-state logic; outputs come from salidas_control_multiciclo.
// Inputs : clk, reset (sync, active-high), opcode (IR[31:26]), zero (ALU flag),
//          mem_ready (memory completes the access this cycle).
// Outputs: pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
//          reg_write, alu_src_a, alu_src_b[1:0], pc_source[1:0], alu_op[2:0],
//          state[3:0] (debug), illegal (high in TRAP).
// Optional feature macro: UCMC_JUMP_EN (opcode 000010 executes as a jump;
//          otherwise it traps).
// -----------------------------------------------------------------------------
module unidad_de_control_multiciclo
  import mips_control_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [2:0] alu_op,
  output logic [3:0] state,
  output logic       illegal
);

  state_t state_q;
  state_t state_d;

  // Next-state sequencing; unknown encodings fall into TRAP
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        if (mem_ready) state_d = ST_DECODE;
        else           state_d = ST_FETCH;
      end
      ST_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:                     state_d = ST_MEMADR;
          OP_RTYPE:                         state_d = ST_REX;
          OP_BEQ:                           state_d = ST_BEQ;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = ST_IEX;
`ifdef UCMC_JUMP_EN
          OP_J:                             state_d = ST_JUMP;
`endif
          default:                          state_d = ST_TRAP;
        endcase
      end
      ST_MEMADR: begin
        if (opcode == OP_SW) state_d = ST_MEMWR;
        else                 state_d = ST_MEMRD;
      end
      ST_MEMRD: begin
        if (mem_ready) state_d = ST_MEMWB;
        else           state_d = ST_MEMRD;
      end
      ST_MEMWR: begin
        if (mem_ready) state_d = ST_FETCH;
        else           state_d = ST_MEMWR;
      end
      ST_MEMWB: state_d = ST_FETCH;
      ST_REX:   state_d = ST_RWB;
      ST_RWB:   state_d = ST_FETCH;
      ST_BEQ:   state_d = ST_FETCH;
      ST_IEX:   state_d = ST_IWB;
      ST_IWB:   state_d = ST_FETCH;
`ifdef UCMC_JUMP_EN
      ST_JUMP:  state_d = ST_FETCH;
`endif
      ST_TRAP:  state_d = ST_TRAP;
      default:  state_d = ST_TRAP;
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  assign state = state_q;

  salidas_control_multiciclo u_salidas (
    .state      (state_q),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .zero       (zero),
    .reset      (reset),
    .pc_en      (pc_en),
    .i_or_d     (i_or_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_source  (pc_source),
    .alu_op     (alu_op),
    .illegal    (illegal)
  );

endmodule

// File: tb/tb_unidad_de_control_multiciclo.sv
// -----------------------------------------------------------------------------
// Self-checking bench for unidad_de_control_multiciclo. Each instruction is
// expanded into the list of states it must visit (with randomized memory wait
// cycles) and the expected outputs of each visited state are taken from a
// table of the documented per-state behaviour.
// -----------------------------------------------------------------------------
module tb_unidad_de_control_multiciclo;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_en, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, illegal;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [3:0] state;

  int n_cmp = 0;
  int n_err = 0;

  logic [20:0] obs_q[$];
  logic [20:0] exp_q[$];

  unidad_de_control_multiciclo dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_source(pc_source), .alu_op(alu_op), .state(state), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Signature layout: state[20:17] pc_en16 i_or_d15 mem_read14 mem_write13
  // ir_write12 reg_dst11 mem_to_reg10 reg_write9 alu_src_a8 srcb[7:6]
  // pcsrc[5:4] alu_op[3:1] illegal0
  function automatic logic [20:0] sig_now();
    return {state, pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst,
            mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_source, alu_op, illegal};
  endfunction

  // Expected outputs of a documented state
  function automatic logic [20:0] exp_sig(input int st, input logic [5:0] op,
                                          input logic mr, input logic z);
    logic pe, iod, mrd, mwr, irw, rd, m2r, rw, sa, ill;
    logic [1:0] sb, ps;
    logic [2:0] ao;
    {pe, iod, mrd, mwr, irw, rd, m2r, rw, sa, ill} = 10'b0;
    sb = 2'b00; ps = 2'b00; ao = 3'b000;
    if (st == 0) begin mrd = 1'b1; sb = 2'b01; irw = mr; pe = mr; end
    else if (st == 1) sb = 2'b11;
    else if (st == 2) begin sa = 1'b1; sb = 2'b10; end
    else if (st == 3) begin mrd = 1'b1; iod = 1'b1; end
    else if (st == 4) begin rw = 1'b1; m2r = 1'b1; end
    else if (st == 5) begin mwr = 1'b1; iod = 1'b1; end
    else if (st == 6) begin sa = 1'b1; ao = 3'b010; end
    else if (st == 7) begin rw = 1'b1; rd = 1'b1; end
    else if (st == 8) begin sa = 1'b1; ao = 3'b001; ps = 2'b01; pe = z; end
    else if (st == 9) begin
      sa = 1'b1; sb = 2'b10;
      if (op == 6'b001100) ao = 3'b101;
      else if (op == 6'b001101) ao = 3'b011;
      else if (op == 6'b001010) ao = 3'b100;
      else ao = 3'b000;
    end
    else if (st == 10) rw = 1'b1;
    else if (st == 11) begin pe = 1'b1; ps = 2'b10; end
    else if (st == 12) ill = 1'b1;
    return {st[3:0], pe, iod, mrd, mwr, irw, rd, m2r, rw, sa, sb, ps, ao, ill};
  endfunction

  // Run one instruction from FETCH: fw/mw = wait cycles in FETCH / MEMRD-MEMWR,
  // zmode 0/1 = fixed zero, 2 = random. Appends observed/expected signatures.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input int zmode);
    int  st_q[$];
    logic mr_q[$];
    bit  trap;
    logic z;
    trap = 1'b0;
    repeat (fw) begin st_q.push_back(0); mr_q.push_back(1'b0); end
    st_q.push_back(0); mr_q.push_back(1'b1);
    st_q.push_back(1); mr_q.push_back(1'($urandom_range(0, 1)));
    case (op)
      6'b100011, 6'b101011: begin
        st_q.push_back(2); mr_q.push_back(1'($urandom_range(0, 1)));
        repeat (mw) begin st_q.push_back(op[3] ? 5 : 3); mr_q.push_back(1'b0); end
        st_q.push_back(op[3] ? 5 : 3); mr_q.push_back(1'b1);
        if (!op[3]) begin st_q.push_back(4); mr_q.push_back(1'($urandom_range(0, 1))); end
      end
      6'b000000: begin st_q.push_back(6); st_q.push_back(7); mr_q.push_back(1'b0); mr_q.push_back(1'b1); end
      6'b000100: begin st_q.push_back(8); mr_q.push_back(1'($urandom_range(0, 1))); end
      6'b001000, 6'b001100, 6'b001101, 6'b001010: begin
        st_q.push_back(9); st_q.push_back(10); mr_q.push_back(1'b1); mr_q.push_back(1'b0);
      end
`ifdef UCMC_JUMP_EN
      6'b000010: begin st_q.push_back(11); mr_q.push_back(1'($urandom_range(0, 1))); end
`endif
      default: begin
        trap = 1'b1;
        repeat (12) begin st_q.push_back(12); mr_q.push_back(1'($urandom_range(0, 1))); end
      end
    endcase
    if (!trap) begin st_q.push_back(0); mr_q.push_back(1'b0); end
    for (int i = 0; i < st_q.size(); i++) begin
      z = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
      opcode = op; mem_ready = mr_q[i]; zero = z;
      @(negedge clk);
      obs_q.push_back(sig_now());
      exp_q.push_back(exp_sig(st_q[i], op, mr_q[i], z));
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b1; opcode = 6'b100011; zero = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if ({pc_en, ir_write, mem_read, mem_write, reg_write} !== 5'b0) begin
      n_err++; $display("FAIL reset_strobes: got %b expected 00000", {pc_en, ir_write, mem_read, mem_write, reg_write});
    end
    n_cmp++;
    if ({state, illegal} !== 5'b0) begin
      n_err++; $display("FAIL reset_state: got state=%0d illegal=%b expected 0/0", state, illegal);
    end
    @(posedge clk); #1;
    reset = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic test_lw();
    obs_q = {}; exp_q = {};
    run_instr(6'b100011, 0, 0, 2);
    run_instr(6'b100011, 2, 3, 2);
    for (int i = 0; i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL lw step %0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_sw_stall();
    int cnt;
    obs_q = {}; exp_q = {};
    run_instr(6'b101011, 0, 3, 2);
    cnt = 0;
    for (int i = 0; i < obs_q.size(); i++) begin
      if (obs_q[i][13]) cnt++;
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL sw_stall step %0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++;
    if (cnt !== 4) begin n_err++; $display("FAIL sw_mem_write_cycles: got %0d expected 4", cnt); end
  endtask

  task automatic test_beq();
    obs_q = {}; exp_q = {};
    run_instr(6'b000100, 0, 0, 1);
    run_instr(6'b000100, 1, 0, 0);
    for (int i = 0; i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL beq step %0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_itype();
    obs_q = {}; exp_q = {};
    run_instr(6'b001101, 0, 0, 2);
    run_instr(6'b001000, 0, 0, 2);
    run_instr(6'b001100, 1, 0, 2);
    run_instr(6'b001010, 0, 0, 2);
    run_instr(6'b000000, 0, 0, 2);
    for (int i = 0; i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL itype_rtype step %0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [9];
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000,
            6'b001100, 6'b001101, 6'b001010, 6'b000000};
    obs_q = {}; exp_q = {};
    for (int k = 0; k < 25; k++)
      run_instr(ops[$urandom_range(0, 8)], $urandom_range(0, 2), $urandom_range(0, 3), 2);
    for (int i = 0; i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL back_to_back step %0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_jump();
    obs_q = {}; exp_q = {};
    run_instr(6'b000010, 0, 0, 2);
    for (int i = 0; i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL jump step %0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
`ifndef UCMC_JUMP_EN
    // J traps in this build: leave TRAP through reset
    reset = 1'b1; @(posedge clk); #1; reset = 1'b0; mem_ready = 1'b0;
`endif
  endtask

  task automatic test_trap();
    obs_q = {}; exp_q = {};
    run_instr(6'b111111, 0, 0, 2);
    for (int i = 0; i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL trap step %0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    reset = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({pc_en, ir_write, mem_read, mem_write, reg_write} !== 5'b0) begin
      n_err++; $display("FAIL trap_reset_strobes: got %b expected 00000", {pc_en, ir_write, mem_read, mem_write, reg_write});
    end
    @(posedge clk); #1;
    reset = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({state, illegal} !== 5'b0) begin
      n_err++; $display("FAIL trap_exit: got state=%0d illegal=%b expected 0/0", state, illegal);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midstall();
    opcode = 6'b101011; mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    mem_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({state, mem_write} !== {4'd5, 1'b1}) begin
      n_err++; $display("FAIL midstall_state: got state=%0d mem_write=%b expected 5/1", state, mem_write);
    end
    reset = 1'b1; #1;
    n_cmp++;
    if ({mem_write, i_or_d & mem_read} !== 2'b00) begin
      n_err++; $display("FAIL midstall_reset_strobe: got mem_write=%b expected 0", mem_write);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({state, mem_write} !== 5'b0) begin
      n_err++; $display("FAIL midstall_abort: got state=%0d mem_write=%b expected 0/0", state, mem_write);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_stall();
    test_beq();
    test_itype();
    test_back_to_back();
    test_reset_midstall();
    test_jump();
    test_trap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
